// File: rtl/sys_ctrl_fifo.sv
// sys_ctrl_fifo: UART system controller with an internal response FIFO.
// Decodes command frames from the UART receiver and drives the register file
// and ALU. Read data and two-frame ALU results are queued in a response FIFO.
// An independent TX sub-FSM drains that FIFO to the transmitter.
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   RX_P_DATA/RX_D_VLD           received byte and its one-cycle strobe
//   Busy, TX_P_DATA/TX_D_VLD     transmitter handshake and byte out
//   ALU_OUT/OUT_Valid            double-width ALU result and its valid
//   ALU_En/ALU_Fun/CLK_En        ALU start pulse, function, clock enable
//   RdData/RdData_Valid          register read data and its valid
//   Address/WrEn/RdEn/WrData     register file access
//   CMD_ERR                      one-cycle error pulse (bad byte or timeout)
module sys_ctrl_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic                    Busy,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_Valid,
    output logic                    ALU_En,
    output logic [3:0]              ALU_Fun,
    output logic                    CLK_En,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdData_Valid,
    output logic [ADDR_WIDTH-1:0]   Address,
    output logic                    WrEn,
    output logic                    RdEn,
    output logic [DATA_WIDTH-1:0]   WrData,
    output logic                    CMD_ERR
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_ISSUE, RD_WAIT,
        OP_A, OP_B, FUN, ALU_ISSUE, ALU_WAIT
    } state_t;
    typedef enum logic [1:0] {T_IDLE, T_WAIT_HI, T_WAIT_LO} tx_state_t;

    state_t    state, state_nxt;
    tx_state_t tx_state, tx_nxt;

    // ---------------- response FIFO ----------------
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr, count;
    logic                  fifo_full, fifo_empty, free2;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] push_data;

    assign count      = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign free2      = (count <= PW'(FIFO_DEPTH - 2));

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // ---------------- timeout ----------------
    logic [TW-1:0] tcnt;
    logic          stalled, running, timeout, byte_acc, hi_pend;

    // Stalling on a full FIFO is not the host's fault, so it does not time out.
    assign stalled = ((state == RD_ISSUE) && fifo_full) || ((state == ALU_ISSUE) && !free2);
    assign running = (state != IDLE) && !stalled;
    // The high-byte push cycle is never cut short, so a result is never split.
    assign timeout = (TIMEOUT_CYC != 0) && running && !hi_pend && (tcnt == TMAX);

    always_ff @(posedge CLK) begin
        if (RST || state == IDLE || state_nxt != state || byte_acc)
            tcnt <= '0;
        else if (running)
            tcnt <= tcnt + TW'(1);
    end

    // ---------------- command FSM ----------------
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timeout) state_nxt = IDLE;
        else begin
            case (state)
                IDLE: if (RX_D_VLD) begin
                    case (RX_P_DATA[7:0])
                        8'hAA:   state_nxt = WR_ADDR;
                        8'hBB:   state_nxt = RD_ADDR;
                        8'hCC:   state_nxt = OP_A;
                        8'hDD:   state_nxt = FUN;
                        default: state_nxt = IDLE;
                    endcase
                end
                WR_ADDR:   if (RX_D_VLD)     state_nxt = WR_DATA;
                WR_DATA:   if (RX_D_VLD)     state_nxt = IDLE;
                RD_ADDR:   if (RX_D_VLD)     state_nxt = RD_ISSUE;
                RD_ISSUE:  if (!fifo_full)   state_nxt = RD_WAIT;
                RD_WAIT:   if (RdData_Valid) state_nxt = IDLE;
                OP_A:      if (RX_D_VLD)     state_nxt = OP_B;
                OP_B:      if (RX_D_VLD)     state_nxt = FUN;
                FUN:       if (RX_D_VLD)     state_nxt = ALU_ISSUE;
                ALU_ISSUE: if (free2)        state_nxt = ALU_WAIT;
                ALU_WAIT:  if (hi_pend)      state_nxt = IDLE;
                default:                     state_nxt = IDLE;
            endcase
        end
    end

    // Next values for the registered outputs and the FIFO push.
    logic                  wr_en_d, rd_en_d, alu_en_d, cmd_err_d, clk_en_d, hi_pend_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d, hi_byte, hi_byte_d;
    logic [3:0]            fun_d;

    always_comb begin
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        cmd_err_d = 1'b0;
        clk_en_d  = CLK_En;
        hi_pend_d = hi_pend;
        hi_byte_d = hi_byte;
        addr_d    = Address;
        wdata_d   = WrData;
        fun_d     = ALU_Fun;
        push      = 1'b0;
        push_data = '0;
        byte_acc  = 1'b0;
        if (timeout) begin
            cmd_err_d = 1'b1;
            clk_en_d  = 1'b0;
            hi_pend_d = 1'b0;
        end else begin
            case (state)
                IDLE: if (RX_D_VLD) begin
                    byte_acc = 1'b1;
                    case (RX_P_DATA[7:0])
                        8'hAA, 8'hBB, 8'hCC: ;
                        8'hDD:   clk_en_d  = 1'b1;
                        default: cmd_err_d = 1'b1;
                    endcase
                end
                WR_ADDR, RD_ADDR: if (RX_D_VLD) begin
                    byte_acc = 1'b1;
                    addr_d   = RX_P_DATA[ADDR_WIDTH-1:0];
                end
                WR_DATA: if (RX_D_VLD) begin
                    byte_acc = 1'b1;
                    wdata_d  = RX_P_DATA;
                    wr_en_d  = 1'b1;
                end
                OP_A: if (RX_D_VLD) begin
                    byte_acc = 1'b1;
                    addr_d   = '0;
                    wdata_d  = RX_P_DATA;
                    wr_en_d  = 1'b1;
                end
                OP_B: if (RX_D_VLD) begin
                    byte_acc = 1'b1;
                    addr_d   = ADDR_WIDTH'(1);
                    wdata_d  = RX_P_DATA;
                    wr_en_d  = 1'b1;
                    clk_en_d = 1'b1;
                end
                FUN: if (RX_D_VLD) begin
                    byte_acc = 1'b1;
                    fun_d    = RX_P_DATA[3:0];
                end
                RD_ISSUE: begin
                    cmd_err_d = RX_D_VLD;
                    rd_en_d   = !fifo_full;
                end
                RD_WAIT: begin
                    cmd_err_d = RX_D_VLD;
                    if (RdData_Valid) begin
                        push      = 1'b1;
                        push_data = RdData;
                    end
                end
                ALU_ISSUE: begin
                    cmd_err_d = RX_D_VLD;
                    alu_en_d  = free2;
                end
                ALU_WAIT: begin
                    cmd_err_d = RX_D_VLD;
                    if (hi_pend) begin
                        push      = 1'b1;
                        push_data = hi_byte;
                        hi_pend_d = 1'b0;
                        clk_en_d  = 1'b0;
                    end else if (OUT_Valid) begin
                        push      = 1'b1;
                        push_data = ALU_OUT[DATA_WIDTH-1:0];
                        hi_byte_d = ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
                        hi_pend_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            WrEn    <= 1'b0;
            RdEn    <= 1'b0;
            ALU_En  <= 1'b0;
            CMD_ERR <= 1'b0;
            CLK_En  <= 1'b0;
            Address <= '0;
            WrData  <= '0;
            ALU_Fun <= '0;
            hi_pend <= 1'b0;
            hi_byte <= '0;
        end else begin
            WrEn    <= wr_en_d;
            RdEn    <= rd_en_d;
            ALU_En  <= alu_en_d;
            CMD_ERR <= cmd_err_d;
            CLK_En  <= clk_en_d;
            Address <= addr_d;
            WrData  <= wdata_d;
            ALU_Fun <= fun_d;
            hi_pend <= hi_pend_d;
            hi_byte <= hi_byte_d;
        end
    end

    // ---------------- TX sub-FSM ----------------
    always_comb begin
        tx_nxt = tx_state;
        pop    = 1'b0;
        case (tx_state)
            T_IDLE: if (!fifo_empty && !Busy) begin
                pop    = 1'b1;
                tx_nxt = T_WAIT_HI;
            end
            T_WAIT_HI: if (Busy)  tx_nxt = T_WAIT_LO;
            T_WAIT_LO: if (!Busy) tx_nxt = T_IDLE;
            default:              tx_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_state  <= T_IDLE;
            TX_D_VLD  <= 1'b0;
            TX_P_DATA <= '0;
        end else begin
            tx_state <= tx_nxt;
            TX_D_VLD <= pop;
            if (pop) TX_P_DATA <= mem[rd_ptr[AW-1:0]];
        end
    end
endmodule

// File: doc/sys_ctrl_fifo.md
Name: sys_ctrl_fifo

Overview:
Parametrised next-generation UART system controller. It decodes command frames arriving from the UART receiver and drives the register file and ALU. Results go into an internal response FIFO, which is drained independently to the UART transmitter. Compared with the previous controller it adds configurable data/address width, a double-width ALU result sent as two frames, and an inter-byte timeout with an error flag.

Parameters:
DATA_WIDTH, 8, width of UART frames, register data and ALU operands
ADDR_WIDTH, 4, register-file address width
FIFO_DEPTH, 8, response FIFO entries; power of two, >= 2
TIMEOUT_CYC, 4096, max idle cycles between frame bytes or while waiting for a result; 0 disables

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
RX_P_DATA  in  DATA_WIDTH  received byte
RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
Busy  in  1  transmitter busy
TX_P_DATA  out  DATA_WIDTH  byte to transmit
TX_D_VLD  out  1  one-cycle strobe to transmitter
ALU_OUT  in  2*DATA_WIDTH  ALU result
OUT_Valid  in  1  ALU result valid
ALU_En  out  1  one-cycle ALU start
ALU_Fun  out  4  ALU function
CLK_En  out  1  ALU clock-gate enable
RdData  in  DATA_WIDTH  register read data
RdData_Valid  in  1  read data valid
Address  out  ADDR_WIDTH  register address
WrEn  out  1  one-cycle write strobe
RdEn  out  1  one-cycle read strobe
WrData  out  DATA_WIDTH  write data
CMD_ERR  out  1  one-cycle error pulse

Behaviour:
- Single clock CLK. RST is synchronous, active-high.
- Reset: all outputs 0; FSM in IDLE; FIFO empty; timeout counter 0; TX side idle.
- Commands (first byte, compared on its low 8 bits):
  - 0xAA: write; next bytes are addr, data.
  - 0xBB: read; next byte is addr.
  - 0xCC: ALU with operands; next bytes are A, B, fun.
  - 0xDD: ALU without operands; next byte is fun.
- Any other first byte is dropped, with a CMD_ERR pulse on the next cycle.
- Address is taken from the low ADDR_WIDTH bits of the addr byte.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_ISSUE, RD_WAIT, OP_A, OP_B, FUN, ALU_ISSUE, ALU_WAIT.
- Write: the cycle after the data byte arrives, WrEn=1 for one cycle with Address/WrData valid; then IDLE.
- Operands: A is written to address 0 and B to address 1, each with a WrEn pulse the cycle after the byte.
- Read:
  - RD_ISSUE waits until FIFO free slots >= 1, then pulses RdEn for one cycle.
  - RD_WAIT pushes RdData on the RdData_Valid cycle, then goes to IDLE.
- ALU:
  - FUN latches ALU_Fun = fun[3:0] and asserts CLK_En.
  - ALU_ISSUE waits for free slots >= 2, then pulses ALU_En.
  - ALU_WAIT, on OUT_Valid: push ALU_OUT[DATA_WIDTH-1:0], then ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH] on the next cycle.
  - CLK_En is held high from FUN entry through the cycle of the second push, then cleared.
- ALU_Fun holds its last value between commands.
- RX_D_VLD while in RD_ISSUE, RD_WAIT, ALU_ISSUE or ALU_WAIT: the byte is dropped and CMD_ERR pulses. The FSM continues.
- Timeout: the counter runs in every non-IDLE state except *_ISSUE while stalled on a full FIFO. It resets on each accepted byte and on each state change.
- When the counter reaches TIMEOUT_CYC:
  - FSM goes to IDLE, CLK_En goes to 0, CMD_ERR pulses.
  - A partial frame is discarded, and nothing is pushed.
  - A late OUT_Valid or RdData_Valid arriving in IDLE is ignored.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)+1-bit pointers; full/empty are distinguished by the MSB.
  - Push and pop in the same cycle are legal; the count is unchanged.
  - Because of the issue-stage reservation, a push never occurs when full.
- TX side (independent sub-FSM T_IDLE, T_WAIT_HI, T_WAIT_LO):
  - T_IDLE: if FIFO is not empty and Busy=0, pop the head, drive TX_P_DATA, pulse TX_D_VLD for one cycle, go to T_WAIT_HI.
  - T_WAIT_HI: wait for Busy=1, then go to T_WAIT_LO.
  - T_WAIT_LO: wait for Busy=0, then go to T_IDLE.
  - TX_P_DATA holds its value after the pulse.
  - Minimum spacing between pulses is 3 cycles.
- RST mid-frame or mid-transmission: everything is cleared and FIFO contents are lost.

Test Plan:
- Frames AA,05,3C -> one WrEn pulse with Address=5, WrData=0x3C; no TX activity.
- Frames BB,05, RdData=0x3C two cycles after RdEn -> exactly one TX_D_VLD with TX_P_DATA=0x3C.
- Frames CC,12,34,00 with ALU_OUT=0x0046 -> WrEn at addr 0 (0x12) and addr 1 (0x34); ALU_En pulse with ALU_Fun=0; CLK_En high until done; TX sends 0x46 then 0x00.
- Frames AA,05 followed by TIMEOUT_CYC idle cycles -> CMD_ERR pulse, no WrEn; a following AA,01,FF is handled normally.
- Unknown byte 0x77 -> CMD_ERR pulse; state stays IDLE.
- Busy held high while 5 DD commands are issued with FIFO_DEPTH=8 -> the 5th command stalls in ALU_ISSUE (only 8 slots); after Busy is released, all 10 bytes are sent in order with no loss or duplication.
